reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 110 +++++++++++
 tb/tb_reg_file.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Architectural register file with per-register ROB rename tags.
// Commit writes values and retires matching tags; reads bypass a same-cycle retiring commit.
module reg_file #(
  parameter int ROB_SIZE_LOG = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic [ROB_SIZE_LOG-1:0] issue_robid,
  input  logic                    commit_enable,
  input  logic [4:0]              commit_regid,
  input  logic [31:0]             commit_value,
  input  logic [ROB_SIZE_LOG-1:0] commit_robid,
  input  logic                    flush,
  input  logic [4:0]              rs1_id,
  input  logic [4:0]              rs2_id,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [ROB_SIZE_LOG-1:0] rs1_robid,
  output logic [ROB_SIZE_LOG-1:0] rs2_robid,
  output logic [31:0]             rs1_value,
  output logic [31:0]             rs2_value
);

  localparam int DATA_W = 32;
  localparam int NREG   = 32;

  typedef logic [ROB_SIZE_LOG-1:0] tag_t;

  typedef struct packed {
    logic              busy;
    tag_t              tag;
    logic [DATA_W-1:0] value;
  } rd_t;

  logic [DATA_W-1:0] value_q [NREG];
  logic [DATA_W-1:0] value_d [NREG];
  tag_t              tag_q   [NREG];
  tag_t              tag_d   [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  logic commit_hit;
  rd_t  rd1;
  rd_t  rd2;

  // A commit retires the rename only if it comes from the youngest writer.
  assign commit_hit = commit_enable && (commit_regid != 5'd0) &&
                      busy_q[commit_regid] && (tag_q[commit_regid] == commit_robid);

  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (rdy) begin
      if (commit_enable && (commit_regid != 5'd0)) begin
        value_d[commit_regid] = commit_value;
        if (commit_hit) busy_d[commit_regid] = 1'b0;
      end
      // Flush drops every rename; otherwise a new claim overrides any same-cycle retire.
      if (flush) begin
        busy_d = '0;
      end else if (issue_valid && (issue_rd != 5'd0)) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_robid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '{default: '0};
      tag_q   <= '{default: '0};
      busy_q  <= '0;
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

  function automatic rd_t read_port(input logic [4:0] id);
    rd_t r;
    r.busy  = busy_q[id];
    r.tag   = tag_q[id];
    r.value = value_q[id];
    if (id == 5'd0) begin
      r = '0;
    end else if (rdy && commit_hit && (id == commit_regid)) begin
      r.busy  = 1'b0;
      r.value = commit_value;
    end
    return r;
  endfunction

  always_comb begin
    rd1 = read_port(rs1_id);
    rd2 = read_port(rs2_id);
  end

  assign rs1_busy  = rd1.busy;
  assign rs1_robid = rd1.tag;
  assign rs1_value = rd1.value;
  assign rs2_busy  = rd2.busy;
  assign rs2_robid = rd2.tag;
  assign rs2_value = rd2.value;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: directed scenarios then randomized traffic
// against an array-based reference model of the register/rename state.
module tb_reg_file;
  localparam int RL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rdy = 1'b0;
  logic          issue_valid = 1'b0;
  logic [4:0]    issue_rd = '0;
  logic [RL-1:0] issue_robid = '0;
  logic          commit_enable = 1'b0;
  logic [4:0]    commit_regid = '0;
  logic [31:0]   commit_value = '0;
  logic [RL-1:0] commit_robid = '0;
  logic          flush = 1'b0;
  logic [4:0]    rs1_id = '0;
  logic [4:0]    rs2_id = '0;
  logic          rs1_busy, rs2_busy;
  logic [RL-1:0] rs1_robid, rs2_robid;
  logic [31:0]   rs1_value, rs2_value;

  reg_file #(.ROB_SIZE_LOG(RL)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_robid(issue_robid),
    .commit_enable(commit_enable), .commit_regid(commit_regid),
    .commit_value(commit_value), .commit_robid(commit_robid),
    .flush(flush), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_robid(rs1_robid), .rs2_robid(rs2_robid),
    .rs1_value(rs1_value), .rs2_value(rs2_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic          busy;
    logic [RL-1:0] tag;
    logic [31:0]   value;
    string         name;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   errors = 0;
  int   checks = 0;

  logic [31:0]   mval [32];
  logic          mbusy[32];
  logic [RL-1:0] mtag [32];

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mval[i] = '0; mbusy[i] = 1'b0; mtag[i] = '0;
    end
  endtask

  function automatic exp_t model_read(int port, logic [4:0] id, string name);
    exp_t e;
    e.port = port; e.name = name;
    e.busy = 1'b0; e.tag = '0; e.value = '0;
    if (id != 0) begin
      e.busy = mbusy[id]; e.tag = mtag[id]; e.value = mval[id];
      if (rdy && commit_enable && commit_regid == id && mbusy[id] && mtag[id] == commit_robid) begin
        e.busy = 1'b0; e.value = commit_value;
      end
    end
    return e;
  endfunction

  // State transition at one clock edge, taken straight from the register-file rules.
  task automatic model_edge();
    if (!rdy) return;
    if (commit_enable && commit_regid != 0) begin
      mval[commit_regid] = commit_value;
      if (mbusy[commit_regid] && mtag[commit_regid] == commit_robid) mbusy[commit_regid] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    end else if (issue_valid && issue_rd != 0) begin
      mbusy[issue_rd] = 1'b1;
      mtag[issue_rd]  = issue_robid;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expected read-port responses whenever a sample point is announced.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.port == 1) begin
          chk({e.name, ".rs1_busy"},  32'(rs1_busy),  32'(e.busy));
          chk({e.name, ".rs1_robid"}, 32'(rs1_robid), 32'(e.tag));
          chk({e.name, ".rs1_value"}, rs1_value,      e.value);
        end else begin
          chk({e.name, ".rs2_busy"},  32'(rs2_busy),  32'(e.busy));
          chk({e.name, ".rs2_robid"}, 32'(rs2_robid), 32'(e.tag));
          chk({e.name, ".rs2_value"}, rs2_value,      e.value);
        end
      end
    end
  end

  // Called with inputs set just after a falling edge; returns at the next falling edge.
  task automatic step(string name);
    #1;
    q.push_back(model_read(1, rs1_id, name));
    q.push_back(model_read(2, rs2_id, name));
    ->sample_ev;
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_robid = '0;
    commit_enable = 1'b0; commit_regid = '0; commit_value = '0; commit_robid = '0;
    flush = 1'b0;
  endtask

  task automatic issue(logic [4:0] rd, logic [RL-1:0] id);
    issue_valid = 1'b1; issue_rd = rd; issue_robid = id;
  endtask

  task automatic commit(logic [4:0] rd, logic [RL-1:0] id, logic [31:0] v);
    commit_enable = 1'b1; commit_regid = rd; commit_robid = id; commit_value = v;
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    idle(); rs1_id = 5; rs2_id = 0;
    step("reset_q5");
    rst_n = 1'b1;

    // Issue then commit with a matching tag: bypass, then stored.
    idle(); issue(5, 3); rs1_id = 5; step("iss5");
    idle(); commit(5, 3, 32'hDEADBEEF); rs1_id = 5; step("byp5");
    idle(); rs1_id = 5; step("post5");

    // Two writers to x7: the older commit must not retire the younger rename.
    idle(); issue(7, 2); step("iss7a");
    idle(); issue(7, 6); step("iss7b");
    idle(); commit(7, 2, 32'h11); rs1_id = 7; step("com7_old");
    idle(); rs1_id = 7; step("post7_old");
    idle(); commit(7, 6, 32'h22); rs1_id = 7; step("com7_new");
    idle(); rs1_id = 7; step("post7_new");

    // Same-cycle issue and commit on x9.
    idle(); issue(9, 1); step("iss9");
    idle(); issue(9, 4); commit(9, 1, 32'h5); rs1_id = 9; step("iss_com9");
    idle(); rs1_id = 9; step("post9");

    // Flush with a commit and an ignored issue.
    idle(); issue(3, 10); step("iss3");
    idle(); issue(4, 11); step("iss4");
    idle(); flush = 1'b1; commit(3, 0, 32'h40); issue(8, 12); rs1_id = 3; rs2_id = 4; step("flush");
    idle(); rs1_id = 3; rs2_id = 8; step("post_flush_a");
    idle(); rs1_id = 4; rs2_id = 7; step("post_flush_b");

    // rdy low freezes everything; x0 is never written.
    idle(); rdy = 1'b0; issue(10, 7); commit(0, 0, 32'h99); rs1_id = 0; rs2_id = 10; step("rdy_low");
    idle(); rs1_id = 10; rs2_id = 0; step("post_rdy_low");

    // Asynchronous reset in the middle of a cycle discards pending claims.
    idle(); issue(12, 3); step("iss12");
    idle(); issue(13, 5); rs1_id = 12; rs2_id = 9;
    #2 rst_n = 1'b0;
    model_clear();
    step("rst_mid");
    rst_n = 1'b1;
    idle(); rs1_id = 13; rs2_id = 5; step("post_rst");

    // Randomized traffic on a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      rdy = ($urandom_range(7) != 0);
      if ($urandom_range(1) == 1) issue(5'($urandom_range(7)), RL'($urandom));
      if ($urandom_range(1) == 1) begin
        commit_regid = 5'($urandom_range(7));
        commit(commit_regid, ($urandom_range(2) != 0) ? mtag[commit_regid] : RL'($urandom), $urandom);
      end
      flush = ($urandom_range(15) == 0);
      rs1_id = 5'($urandom_range(7));
      rs2_id = ($urandom_range(3) == 0) ? commit_regid : 5'($urandom_range(31));
      step("rand");
    end

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
